// File: rtl/nn_sample_driver.sv
// nn_sample_driver: feeds stored iris samples to the classifier and scores results.
// Optional low-confidence counter enabled with `define NN_CONF_THRESH_EN.
module nn_sample_driver #(
  parameter int          NUM_SAMPLES   = 16,
  parameter int          ADDR_W        = 8,
  parameter int          CNT_W         = 8,
  parameter int          SETTLE_CYCLES = 16,
  parameter logic [31:0] CONF_THRESH   = 32'h3F000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [17:0]       mem_rdata,
  output logic [3:0]        sl,
  output logic [3:0]        sw,
  output logic [3:0]        pl,
  output logic [3:0]        pw,
  input  logic [3:0]        species,
  input  logic [31:0]       final_val,
  output logic              busy,
  output logic              done,
  output logic              result_valid,
  output logic [3:0]        last_species,
  output logic [31:0]       last_final,
  output logic              mismatch,
  output logic [CNT_W-1:0]  correct_cnt,
  output logic [CNT_W-1:0]  mismatch_cnt,
  output logic [CNT_W-1:0]  lowconf_cnt
);

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, SETTLE, CAPTURE, DONE
  } state_t;

  localparam int SC_W =
    (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SC_W-1:0] SC_LAST =
    SC_W'(SETTLE_CYCLES - 1);
  localparam logic [ADDR_W-1:0] A_LAST =
    ADDR_W'(NUM_SAMPLES - 1);
  localparam logic [CNT_W-1:0] C_MAX = '1;

  state_t          state_q;
  state_t          state_d;
  logic [SC_W-1:0] settle_q;
  logic [1:0]      label_q;
  logic            hit;
  logic            go;

  // label 3 has no matching class, so it can never score as correct
  assign hit = (label_q != 2'b11) &&
               (species == {2'b00, label_q});
  assign go  = start &&
               ((state_q == IDLE) || (state_q == DONE));

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (start) state_d = FETCH;
      FETCH:      state_d = LOAD;
      LOAD:       state_d = SETTLE;
      SETTLE:     if (settle_q == SC_LAST) state_d = CAPTURE;
      CAPTURE:    state_d = (mem_addr == A_LAST) ? DONE : FETCH;
      default:    state_d = IDLE;
    endcase
  end

  // datapath: address, feature latch, capture and scoring
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr     <= '0;
      {label_q, sl, sw, pl, pw} <= '0;
      settle_q     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      result_valid <= 1'b0;
      mismatch     <= 1'b0;
      last_species <= '0;
      last_final   <= '0;
      correct_cnt  <= '0;
      mismatch_cnt <= '0;
    end else begin
      result_valid <= 1'b0;
      mismatch     <= 1'b0;
      if (go) begin
        mem_addr     <= '0;
        correct_cnt  <= '0;
        mismatch_cnt <= '0;
        done         <= 1'b0;
        busy         <= 1'b1;
      end
      if (state_q == LOAD) begin
        {label_q, sl, sw, pl, pw} <= mem_rdata;
        settle_q <= '0;
      end
      if (state_q == SETTLE) settle_q <= settle_q + 1'b1;
      if (state_q == CAPTURE) begin
        last_species <= species;
        last_final   <= final_val;
        result_valid <= 1'b1;
        if (hit) begin
          if (correct_cnt != C_MAX)
            correct_cnt <= correct_cnt + 1'b1;
        end else begin
          mismatch <= 1'b1;
          if (mismatch_cnt != C_MAX)
            mismatch_cnt <= mismatch_cnt + 1'b1;
        end
        if (mem_addr == A_LAST) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          mem_addr <= mem_addr + 1'b1;
        end
      end
    end
  end

`ifdef NN_CONF_THRESH_EN
  // count captures whose confidence falls below threshold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lowconf_cnt <= '0;
    end else if (go) begin
      lowconf_cnt <= '0;
    end else if (state_q == CAPTURE &&
                 final_val < CONF_THRESH &&
                 lowconf_cnt != C_MAX) begin
      lowconf_cnt <= lowconf_cnt + 1'b1;
    end
  end
`else
  logic unused_thresh;
  assign unused_thresh = ^CONF_THRESH;
  assign lowconf_cnt   = '0;
`endif

endmodule

// File: tb/tb_nn_sample_driver.sv
// tb_nn_sample_driver: directed bench for nn_sample_driver.
// Six samples, two settle cycles, 2-bit counters.
module tb_nn_sample_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  mem_addr;
  logic [17:0] mem_rdata = '0;
  logic [3:0]  sl, sw, pl, pw;
  logic [3:0]  species;
  logic [31:0] final_val;
  logic        busy, done, result_valid, mismatch;
  logic [3:0]  last_species;
  logic [31:0] last_final;
  logic [1:0]  correct_cnt, mismatch_cnt, lowconf_cnt;

`ifdef NN_CONF_THRESH_EN
  localparam logic [1:0] LC = 2'd1;
`else
  localparam logic [1:0] LC = 2'd0;
`endif

  logic [17:0] mem [8];
  logic [3:0]  sp  [8];
  logic [31:0] fin [8];

  int n_chk = 0;
  int n_fail = 0;
  int cyc, rv_n, first_rv, last_rv, mm_n, orphan, done_at;

  nn_sample_driver #(
    .NUM_SAMPLES(6), .ADDR_W(8), .CNT_W(2),
    .SETTLE_CYCLES(2), .CONF_THRESH(32'h3F000000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .sl(sl), .sw(sw), .pl(pl), .pw(pw),
    .species(species), .final_val(final_val),
    .busy(busy), .done(done),
    .result_valid(result_valid),
    .last_species(last_species),
    .last_final(last_final),
    .mismatch(mismatch),
    .correct_cnt(correct_cnt),
    .mismatch_cnt(mismatch_cnt),
    .lowconf_cnt(lowconf_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_rdata <= mem[mem_addr[2:0]];
  assign species   = sp[mem_addr[2:0]];
  assign final_val = fin[mem_addr[2:0]];

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    cyc = 0; rv_n = 0; first_rv = 0; last_rv = 0;
    mm_n = 0; orphan = 0; done_at = 0;
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (result_valid) begin
      rv_n++;
      if (first_rv == 0) first_rv = cyc;
      last_rv = cyc;
    end
    if (mismatch) mm_n++;
    if (mismatch && !result_valid) orphan++;
    if (done && done_at == 0) done_at = cyc;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_a"}, {mem_addr, sl, sw, pl, pw, busy, done,
                      result_valid, mismatch, last_species}, 64'd0);
    chk({tag, "_b"}, {last_final, correct_cnt, mismatch_cnt,
                      lowconf_cnt}, 64'd0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_out();
    while (cyc < 40 && !done) step();
  endtask

  initial begin
    mem[0] = 18'h0_1234; sp[0] = 4'd0;
    mem[1] = 18'h1_5678; sp[1] = 4'd1;
    mem[2] = 18'h2_9ABC; sp[2] = 4'd2;
    mem[3] = 18'h0_DEF0; sp[3] = 4'd0;
    mem[4] = 18'h1_2468; sp[4] = 4'd1;
    mem[5] = 18'h2_1357; sp[5] = 4'd2;
    mem[6] = '0; sp[6] = '0;
    mem[7] = '0; sp[7] = '0;
    fin[0] = 32'h3E800000;
    for (int i = 1; i < 8; i++) fin[i] = 32'h3F400000;

    clr();
    step(); step();
    chk_zero("reset");
    rst_n = 1'b1;
    step();
    chk_zero("idle");

    // run 1: all correct, counter saturation, timing
    clr();
    pulse_start();
    chk("r1_busy", {busy, done, mem_addr}, {1'b1, 1'b0, 8'd0});
    step(); step();
    chk("r1_feat0", {sl, sw, pl, pw}, 16'h1234);
    run_out();
    chk("r1_done_at", done_at, 31);
    chk("r1_rv", {rv_n[7:0], first_rv[7:0], last_rv[7:0]},
        {8'd6, 8'd6, 8'd31});
    chk("r1_mm", mm_n, 0);
    chk("r1_cnt", {correct_cnt, mismatch_cnt}, {2'd3, 2'd0});
    chk("r1_lowconf", lowconf_cnt, LC);
    chk("r1_end", {busy, done, mem_addr}, {1'b0, 1'b1, 8'd5});
    chk("r1_hold", {sl, sw, pl, pw}, 16'h1357);
    chk("r1_last", {last_species, last_final},
        {4'd2, 32'h3F400000});
    step(); step();
    chk("r1_done_hold", {busy, done}, 2'b01);

    // run 2: mismatches, feature hold, ignored starts
    mem[0] = 18'h1_A5C3; sp[0] = 4'd2;
    mem[1] = 18'h3_1234; sp[1] = 4'd3;
    clr();
    pulse_start();
    chk("r2_clear", {busy, done, mem_addr, correct_cnt,
                     mismatch_cnt}, {1'b1, 1'b0, 8'd0, 4'd0});
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("r2_feat0", {sl, sw, pl, pw}, 16'hA5C3);
    step(); step();
    chk("r2_feat_hold", {sl, sw, pl, pw}, 16'hA5C3);
    step();
    chk("r2_s0", {result_valid, mismatch, mismatch_cnt,
                  correct_cnt, last_species},
        {1'b1, 1'b1, 2'd1, 2'd0, 4'd2});
    chk("r2_s0_final", last_final, 32'h3E800000);
    chk("r2_s0_lc", lowconf_cnt, LC);
    while (cyc < 11) step();
    chk("r2_s1", {result_valid, mismatch, mismatch_cnt,
                  last_species}, {1'b1, 1'b1, 2'd2, 4'd3});
    while (cyc < 16) step();
    chk("r2_s2", {result_valid, mismatch, correct_cnt},
        {1'b1, 1'b0, 2'd1});
    while (cyc < 30) step();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("r2_edge_start", {busy, done, mem_addr},
        {1'b0, 1'b1, 8'd5});
    chk("r2_done_at", done_at, 31);
    chk("r2_pulses", {rv_n[7:0], mm_n[7:0], orphan[7:0]},
        {8'd6, 8'd2, 8'd0});
    chk("r2_cnt", {correct_cnt, mismatch_cnt}, {2'd3, 2'd2});
    chk("r2_lowconf", lowconf_cnt, LC);

    // run 3: reset during sample 3 settle, then restart
    clr();
    pulse_start();
    while (cyc < 18) step();
    chk("r3_pre", {busy, mem_addr, correct_cnt, mismatch_cnt},
        {1'b1, 8'd3, 2'd1, 2'd2});
    rst_n = 1'b0;
    #1;
    chk_zero("r3_async");
    step();
    rst_n = 1'b1;
    step(); step();
    chk_zero("r3_idle");
    clr();
    pulse_start();
    chk("r3_restart", {busy, done, mem_addr}, {1'b1, 1'b0, 8'd0});
    step(); step();
    chk("r3_feat0", {sl, sw, pl, pw}, 16'hA5C3);
    run_out();
    chk("r3_done_at", done_at, 31);
    chk("r3_cnt", {correct_cnt, mismatch_cnt}, {2'd3, 2'd2});

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
